// File: rtl/fp_pkg.sv
// Shared widths, class-flag bit positions and skid-buffer states for the FP multiplier output path.
package fp_pkg;
    localparam int N_EXP_D = 11;
    localparam int N_MAN_D = 52;

    localparam int FLAG_NORM  = 0;
    localparam int FLAG_DNORM = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_INF   = 3;
    localparam int FLAG_NAN   = 4;
    localparam int FLAG_ERR   = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;
endpackage

// File: rtl/fp_skid_buf.sv
// Generic 2-entry skid buffer: M drives the output, S catches one extra entry.
// Latency 1 cycle; full throughput while out_ready is high.
// in_ready depends only on buffer state (low when both entries are occupied).
module fp_skid_buf
    import fp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_t  state, state_nxt;
    logic [W-1:0] m_q, s_q;
    logic         acc, dlv;
    logic         load_m, m_from_s, load_s;

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = m_q;
    assign acc       = in_valid && in_ready;
    assign dlv       = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        m_from_s  = 1'b0;
        load_s    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_nxt = ST_ONE;
                    load_m    = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && !dlv) begin
                    state_nxt = ST_TWO;
                    load_s    = 1'b1;
                end else if (acc && dlv) begin
                    load_m = 1'b1;
                end else if (dlv) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (dlv) begin
                    state_nxt = ST_ONE;
                    load_m    = 1'b1;
                    m_from_s  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load_m) m_q <= m_from_s ? s_q : in_data;
            if (load_s) s_q <= in_data;
        end
    end
endmodule

// File: rtl/fp_mul_out_stage.sv
// Registered output stage for the FP multiplier: skid buffer plus sticky class flags and event counters.
// Latency 1 cycle; in_ready drops only when both buffer entries are full.
// Counters and the cnt_val mux exist only when FP_MUL_OUT_CNT_EN is defined; otherwise cnt_val reads 0.
module fp_mul_out_stage
    import fp_pkg::*;
#(
    parameter int N_EXP = N_EXP_D,
    parameter int N_MAN = N_MAN_D,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_EXP+N_MAN:0]   in_p,
    input  logic [4:0]             in_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_EXP+N_MAN:0]   out_p,
    output logic [4:0]             out_flags,
    output logic [5:0]             sticky_flags,
    input  logic                   clr_sticky,
    input  logic [2:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_val
);
    localparam int PW = N_EXP + N_MAN + 1;

    logic          acc;
    logic          one_hot, exp_ones, flag_err;
    logic [5:0]    ev;
    logic [5:0]    sticky_q;

    fp_skid_buf #(.W(PW + 5)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_flags, in_p}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_flags, out_p})
    );

    assign acc      = in_valid && in_ready;
    assign one_hot  = $onehot(in_flags);
    assign exp_ones = &in_p[N_EXP+N_MAN-1:N_MAN];
    // An inf tag on a non-max exponent means the multiplier's classifier disagrees with its own data
    assign flag_err = !one_hot || (in_flags[FLAG_INF] && !exp_ones);
    assign ev       = {flag_err, in_flags};

    assign sticky_flags = sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (clr_sticky ? 6'd0 : sticky_q) | (acc ? ev : 6'd0);
        end
    end

`ifdef FP_MUL_OUT_CNT_EN
    logic [CNT_W-1:0] cnt_q   [6];
    logic [CNT_W-1:0] cnt_nxt [6];

    // Clear first, then count the same-cycle accept on top of the cleared value
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            cnt_nxt[i] = clr_sticky ? '0 : cnt_q[i];
            if (acc && ev[i] && (cnt_nxt[i] != {CNT_W{1'b1}}))
                cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_nxt[i];
        end
    end

    always_comb begin
        cnt_val = '0;
        if (cnt_sel < 3'd6) cnt_val = cnt_q[cnt_sel];
    end
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_val        = '0;
`endif
endmodule

// File: tb/tb_fp_mul_out_stage.sv
// Randomised and directed checks of fp_mul_out_stage against a queue-based reference model.
module tb_fp_mul_out_stage;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FP_MUL_OUT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_p;
    logic [4:0]       in_flags;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_p;
    logic [4:0]       out_flags;
    logic [5:0]       sticky_flags;
    logic             clr_sticky;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val;

    always #5 clk = ~clk;

    fp_mul_out_stage #(.N_EXP(11), .N_MAN(52), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_p         (in_p),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_p        (out_p),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .clr_sticky   (clr_sticky),
        .cnt_sel      (cnt_sel),
        .cnt_val      (cnt_val)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [68:0] exp_q[$];
    int          exp_cnt[6];
    logic [5:0]  exp_sticky;

    task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [5:0] events(input logic [63:0] p, input logic [4:0] f);
        logic err;
        err = ($countones(f) != 1) || (f[3] && (p[62:52] != 11'h7FF));
        return {err, f};
    endfunction

    function automatic int exp_cnt_val(input int sel);
        if (!CNT_EN || sel > 5) return 0;
        return exp_cnt[sel];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        exp_sticky = '0;
        for (int i = 0; i < 6; i++) exp_cnt[i] = 0;
    endtask

    // Apply inputs after the falling edge, check pre-edge outputs, clock once, advance the model
    task automatic cycle(input logic v, input logic [63:0] p, input logic [4:0] f,
                         input logic ordy, input logic clr, input logic [2:0] sel);
        logic       acc, dlv;
        logic [5:0] ev;
        in_valid = v; in_p = p; in_flags = f;
        out_ready = ordy; clr_sticky = clr; cnt_sel = sel;
        #1;
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("out_data", {out_flags, out_p}, exp_q[0]);
        chk("sticky", sticky_flags, exp_sticky);
        chk("cnt_val", cnt_val, exp_cnt_val(sel));
        acc = v && (exp_q.size() < 2);
        dlv = ordy && (exp_q.size() > 0);
        @(posedge clk);
        ev = events(p, f);
        if (dlv) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({f, p});
        if (clr) model_clear_counts();
        if (acc) begin
            exp_sticky |= ev;
            for (int i = 0; i < 6; i++)
                if (ev[i] && exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
        end
        @(negedge clk);
    endtask

    task automatic model_clear_counts();
        exp_sticky = '0;
        for (int i = 0; i < 6; i++) exp_cnt[i] = 0;
    endtask

    // Reset with a valid input present; that entry must be neither stored nor counted
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; in_p = 64'h3FF0000000000000; in_flags = 5'b00001;
        out_ready = 1'b0; clr_sticky = 1'b0; cnt_sel = 3'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_clear();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_p", out_p, 64'h0);
        chk("rst_out_flags", out_flags, 5'b0);
        chk("rst_sticky", sticky_flags, 6'b0);
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            chk("rst_cnt", cnt_val, 0);
        end
    endtask

    task automatic idle_read(input logic [2:0] sel);
        cycle(1'b0, 64'h0, 5'b0, 1'b1, 1'b0, sel);
    endtask

    initial begin
        logic [63:0] p;
        logic [4:0]  f;
        rst = 1'b1; in_valid = 1'b0; in_p = '0; in_flags = '0;
        out_ready = 1'b0; clr_sticky = 1'b0; cnt_sel = '0;
        model_clear();
        @(negedge clk);
        do_reset();

        // single transfer
        cycle(1'b1, 64'h4018000000000000, 5'b00001, 1'b1, 1'b0, 3'd0);
        chk("single_p", out_p, 64'h4018000000000000);
        chk("single_flags", out_flags, 5'b00001);
        idle_read(3'd0);

        // backpressure: A, B fill the buffer, C is held off until space frees
        cycle(1'b1, 64'hA, 5'b00001, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 64'hB, 5'b00001, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 64'hC, 5'b00001, 1'b0, 1'b0, 3'd0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        cycle(1'b1, 64'hC, 5'b00001, 1'b1, 1'b0, 3'd0);
        cycle(1'b1, 64'hC, 5'b00001, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) idle_read(3'd0);

        // inf tag with a non-max exponent
        cycle(1'b1, 64'h0000000000000001, 5'b01000, 1'b1, 1'b0, 3'd5);
        chk("ferr_p", out_p, 64'h0000000000000001);
        chk("ferr_sticky5", sticky_flags[5], 1'b1);
        idle_read(3'd5);

        // saturation
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 64'h7FF0000000000000, 5'b01000, 1'b1, 1'b0, 3'd3);
        idle_read(3'd3);

        // clear in the same cycle as a nan accept
        cycle(1'b1, 64'h7FF8000000000000, 5'b10000, 1'b1, 1'b1, 3'd4);
        chk("clr_sticky", sticky_flags, 6'b010000);
        for (int s = 0; s < 8; s++) idle_read(3'(s));

        // reset while holding two entries
        cycle(1'b1, 64'h1, 5'b00100, 1'b0, 1'b0, 3'd2);
        cycle(1'b1, 64'h2, 5'b00100, 1'b0, 1'b0, 3'd2);
        chk("two_in_ready", in_ready, 1'b0);
        do_reset();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            p = {$urandom, $urandom};
            f = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) f = 5'($urandom);
            if (f[3] && $urandom_range(0, 3) != 0) p[62:52] = 11'h7FF;
            cycle($urandom_range(0, 3) != 0, p, f, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
